// File: rtl/mem_arb_pkg.sv
// ---------------------------------------------------------------------------
// mem_arb_pkg
// Shared definitions for the external-RAM arbiter: FSM state encoding,
// requester count, requester index constants and a one-hot decode helper.
// ---------------------------------------------------------------------------
package mem_arb_pkg;

  localparam int NUM_REQ   = 4;
  localparam int REQ_VGA   = 0;
  localparam int REQ_AUDIO = 1;
  localparam int REQ_IO    = 2;
  localparam int REQ_CORE  = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETUP   = 2'd1,
    ACCESS  = 2'd2,
    RECOVER = 2'd3
  } state_e;

  // Index of the set bit of a one-hot requester vector (0 when empty).
  function automatic logic [1:0] onehot_to_idx(input logic [NUM_REQ-1:0] oh);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (oh[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/arb_picker.sv
// ---------------------------------------------------------------------------
// arb_picker
// Combinational winner selection. Searches the request vector starting at
// 'pointer' and wrapping modulo NUM_REQ; the first set request wins.
// With pointer tied to 0 this is fixed priority 0 > 1 > 2 > 3.
// Ports:
//   req     in  NUM_REQ  request vector
//   pointer in  2        search start index
//   winner  out NUM_REQ  one-hot winner (all zero when no request)
// ---------------------------------------------------------------------------
module arb_picker
  import mem_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [1:0]         pointer,
  output logic [NUM_REQ-1:0] winner
);

  logic       found;
  logic [1:0] idx;

  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = 2'd0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = pointer + 2'(i);  // wraps naturally in 2 bits
      if (!found && req[idx]) begin
        winner[idx] = 1'b1;
        found       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
// Four-requester arbiter for an asynchronous external RAM. Each access runs
// IDLE -> SETUP (1 cycle, address strobe) -> ACCESS (ACCESS_CYCLES cycles)
// -> RECOVER (1 cycle, done pulse) -> IDLE. All RAM strobes are registered.
//
// Build option: define MEM_ARB_ROUND_ROBIN_EN for round-robin arbitration;
// otherwise fixed priority VGA > audio > IO > core with no pointer register.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   req, we              per-requester request / write enable (0 VGA..3 core)
//   addr, wdata          packed per-requester address / write data
//   grant                one-hot owner of the current access
//   done                 one-cycle completion pulse to the owner
//   rdata                data of the last completed read
//   mem_addr, mem_dq_o   RAM address / write data (held while idle)
//   mem_dq_oe            RAM data bus output enable
//   mem_dq_i             RAM read data
//   mem_cs_n, mem_adv_n, mem_oe_n, mem_we_n   active-low RAM strobes
// ---------------------------------------------------------------------------
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH    = 24,
  parameter int DATA_WIDTH    = 16,
  parameter int ACCESS_CYCLES = 7
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ-1:0]            we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] wdata,
  output logic [NUM_REQ-1:0]            grant,
  output logic [NUM_REQ-1:0]            done,
  output logic [DATA_WIDTH-1:0]         rdata,
  output logic [ADDR_WIDTH-1:0]         mem_addr,
  output logic [DATA_WIDTH-1:0]         mem_dq_o,
  output logic                          mem_dq_oe,
  input  logic [DATA_WIDTH-1:0]         mem_dq_i,
  output logic                          mem_cs_n,
  output logic                          mem_adv_n,
  output logic                          mem_oe_n,
  output logic                          mem_we_n
);

  state_e                  state_q, state_d;
  logic [NUM_REQ-1:0]      grant_q, grant_d;
  logic [NUM_REQ-1:0]      done_q, done_d;
  logic                    we_q, we_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0]   mem_dq_o_q, mem_dq_o_d;
  logic                    mem_dq_oe_q, mem_dq_oe_d;
  logic                    mem_cs_n_q, mem_cs_n_d;
  logic                    mem_adv_n_q, mem_adv_n_d;
  logic                    mem_oe_n_q, mem_oe_n_d;
  logic                    mem_we_n_q, mem_we_n_d;

  logic [NUM_REQ-1:0]      winner;
  logic [1:0]              win_idx;
  logic [1:0]              pick_ptr;

  arb_picker u_picker (
    .req     (req),
    .pointer (pick_ptr),
    .winner  (winner)
  );

  assign win_idx = onehot_to_idx(winner);

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // Pointer holds the next search start: one past the last winner.
  logic [1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (state_q == IDLE && |req) ptr_d = win_idx + 2'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= 2'd0;
    else        ptr_q <= ptr_d;
  end

  assign pick_ptr = ptr_q;
`else
  assign pick_ptr = 2'd0;
`endif

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    done_d      = '0;
    we_d        = we_q;
    cnt_d       = cnt_q;
    rdata_d     = rdata_q;
    mem_addr_d  = mem_addr_q;
    mem_dq_o_d  = mem_dq_o_q;
    mem_dq_oe_d = mem_dq_oe_q;
    mem_cs_n_d  = mem_cs_n_q;
    mem_adv_n_d = mem_adv_n_q;
    mem_oe_n_d  = mem_oe_n_q;
    mem_we_n_d  = mem_we_n_q;
    case (state_q)
      IDLE: begin
        if (|req) begin
          // Latch the winner's request; later input changes are ignored.
          grant_d     = winner;
          we_d        = we[win_idx];
          mem_addr_d  = addr[int'(win_idx)*ADDR_WIDTH +: ADDR_WIDTH];
          mem_dq_o_d  = wdata[int'(win_idx)*DATA_WIDTH +: DATA_WIDTH];
          mem_dq_oe_d = we[win_idx];
          mem_cs_n_d  = 1'b0;
          mem_adv_n_d = 1'b0;
          state_d     = SETUP;
        end
      end
      SETUP: begin
        mem_adv_n_d = 1'b1;
        mem_oe_n_d  = we_q;
        mem_we_n_d  = ~we_q;
        cnt_d       = 4'(ACCESS_CYCLES - 1);
        state_d     = ACCESS;
      end
      ACCESS: begin
        if (cnt_q == 4'd0) begin
          // Edge ending the last ACCESS cycle: release bus, sample read data.
          mem_cs_n_d  = 1'b1;
          mem_oe_n_d  = 1'b1;
          mem_we_n_d  = 1'b1;
          mem_dq_oe_d = 1'b0;
          done_d      = grant_q;
          if (!we_q) rdata_d = mem_dq_i;
          state_d     = RECOVER;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RECOVER: begin
        grant_d = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      done_q      <= '0;
      we_q        <= 1'b0;
      cnt_q       <= 4'd0;
      rdata_q     <= '0;
      mem_addr_q  <= '0;
      mem_dq_o_q  <= '0;
      mem_dq_oe_q <= 1'b0;
      mem_cs_n_q  <= 1'b1;
      mem_adv_n_q <= 1'b1;
      mem_oe_n_q  <= 1'b1;
      mem_we_n_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      done_q      <= done_d;
      we_q        <= we_d;
      cnt_q       <= cnt_d;
      rdata_q     <= rdata_d;
      mem_addr_q  <= mem_addr_d;
      mem_dq_o_q  <= mem_dq_o_d;
      mem_dq_oe_q <= mem_dq_oe_d;
      mem_cs_n_q  <= mem_cs_n_d;
      mem_adv_n_q <= mem_adv_n_d;
      mem_oe_n_q  <= mem_oe_n_d;
      mem_we_n_q  <= mem_we_n_d;
    end
  end

  assign grant     = grant_q;
  assign done      = done_q;
  assign rdata     = rdata_q;
  assign mem_addr  = mem_addr_q;
  assign mem_dq_o  = mem_dq_o_q;
  assign mem_dq_oe = mem_dq_oe_q;
  assign mem_cs_n  = mem_cs_n_q;
  assign mem_adv_n = mem_adv_n_q;
  assign mem_oe_n  = mem_oe_n_q;
  assign mem_we_n  = mem_we_n_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
// Self-checking bench for mem_arbiter (ACCESS_CYCLES = 7). The reference
// model picks winners from the arbitration rule (fixed priority, or
// round-robin when MEM_ARB_ROUND_ROBIN_EN is defined) and derives the
// expected strobe timeline of each access from the cycle budget.
// ---------------------------------------------------------------------------
module tb_mem_arbiter;

  localparam int AW = 24;
  localparam int DW = 16;
  localparam int AC = 7;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [3:0]      req = '0;
  logic [3:0]      we = '0;
  logic [4*AW-1:0] addr = '0;
  logic [4*DW-1:0] wdata = '0;
  logic [DW-1:0]   mem_dq_i = '0;
  logic [3:0]      grant, done;
  logic [DW-1:0]   rdata, mem_dq_o;
  logic [AW-1:0]   mem_addr;
  logic            mem_dq_oe, mem_cs_n, mem_adv_n, mem_oe_n, mem_we_n;

  int            n_checks = 0;
  int            n_fail = 0;
  int            rr_next = 0;
  logic [DW-1:0] exp_rdata = '0;

  mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ACCESS_CYCLES(AC)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .grant(grant), .done(done), .rdata(rdata), .mem_addr(mem_addr),
    .mem_dq_o(mem_dq_o), .mem_dq_oe(mem_dq_oe), .mem_dq_i(mem_dq_i),
    .mem_cs_n(mem_cs_n), .mem_adv_n(mem_adv_n), .mem_oe_n(mem_oe_n),
    .mem_we_n(mem_we_n)
  );

  always #5 clk = ~clk;

  // Reference arbitration rule.
  function automatic int model_pick(input logic [3:0] r);
    int start;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    start = rr_next;
`else
    start = 0;
`endif
    for (int i = 0; i < 4; i++) begin
      if (r[(start + i) % 4]) return (start + i) % 4;
    end
    return -1;
  endfunction

  task automatic randomize_inputs();
    for (int i = 0; i < 4; i++) begin
      addr[i*AW +: AW]  = AW'($urandom);
      wdata[i*DW +: DW] = DW'($urandom);
    end
    we = 4'($urandom);
  endtask

  // Follows one access from the IDLE sampling edge to the next IDLE cycle.
  // Called at the falling edge just before the sampling edge.
  // mode 1: scramble addr/wdata/we after the first ACCESS cycle.
  // mode 2: drop the owner's req in the third ACCESS cycle.
  task automatic observe(input int w, input int mode);
    logic [3:0]    oh;
    logic          ew;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    logic [4:0]    es;
    oh = 4'(1 << w);
    ew = we[w];
    ea = addr[w*AW +: AW];
    ed = wdata[w*DW +: DW];
`ifdef MEM_ARB_ROUND_ROBIN_EN
    rr_next = (w + 1) % 4;
`endif
    @(negedge clk);  // SETUP
    n_checks++;
    if ({grant, done, mem_cs_n, mem_adv_n, mem_oe_n, mem_we_n, mem_dq_oe} !== {oh, 4'b0, 4'b0011, ew}) begin
      n_fail++;
      $display("FAIL setup: grant/done/strobes=%b %b %b%b%b%b%b required %b 0000 0011%b",
               grant, done, mem_cs_n, mem_adv_n, mem_oe_n, mem_we_n, mem_dq_oe, oh, ew);
    end
    n_checks++;
    if (mem_addr !== ea) begin
      n_fail++;
      $display("FAIL setup_addr: mem_addr=%h required %h", mem_addr, ea);
    end
    if (ew) begin
      n_checks++;
      if (mem_dq_o !== ed) begin
        n_fail++;
        $display("FAIL setup_dq: mem_dq_o=%h required %h", mem_dq_o, ed);
      end
    end
    for (int k = 1; k <= AC; k++) begin
      @(negedge clk);  // ACCESS cycle k
      es = {1'b0, 1'b1, ew, ~ew, ew};
      n_checks++;
      if ({grant, done, mem_cs_n, mem_adv_n, mem_oe_n, mem_we_n, mem_dq_oe, mem_addr} !== {oh, 4'b0, es, ea}) begin
        n_fail++;
        $display("FAIL access%0d: grant=%b done=%b strobes=%b%b%b%b%b addr=%h required %b 0000 %b %h",
                 k, grant, done, mem_cs_n, mem_adv_n, mem_oe_n, mem_we_n, mem_dq_oe, mem_addr, oh, es, ea);
      end
      if (mode == 1 && k == 1) randomize_inputs();
      if (mode == 2 && k == 3) req[w] = 1'b0;
    end
    if (!ew) exp_rdata = mem_dq_i;
    @(negedge clk);  // RECOVER
    n_checks++;
    if ({grant, done, mem_cs_n, mem_adv_n, mem_oe_n, mem_we_n, mem_dq_oe} !== {oh, oh, 5'b11110}) begin
      n_fail++;
      $display("FAIL recover: grant=%b done=%b strobes=%b%b%b%b%b required %b %b 11110",
               grant, done, mem_cs_n, mem_adv_n, mem_oe_n, mem_we_n, mem_dq_oe, oh, oh);
    end
    n_checks++;
    if (rdata !== exp_rdata) begin
      n_fail++;
      $display("FAIL rdata: rdata=%h required %h", rdata, exp_rdata);
    end
    @(negedge clk);  // back in IDLE
    n_checks++;
    if ({grant, done, mem_cs_n, mem_adv_n, mem_oe_n, mem_we_n, mem_dq_oe, mem_addr} !== {4'b0, 4'b0, 5'b11110, ea}) begin
      n_fail++;
      $display("FAIL idle_after: grant=%b done=%b strobes=%b%b%b%b%b addr=%h required 0000 0000 11110 %h",
               grant, done, mem_cs_n, mem_adv_n, mem_oe_n, mem_we_n, mem_dq_oe, mem_addr, ea);
    end
    if (ew) begin
      n_checks++;
      if (mem_dq_o !== ed) begin
        n_fail++;
        $display("FAIL idle_dq_hold: mem_dq_o=%h required %h", mem_dq_o, ed);
      end
    end
    $display("access owner=%0d we=%0b addr=%h wdata=%h rdata=%h mode=%0d", w, ew, ea, ed, rdata, mode);
  endtask

  task automatic check_reset_state(input string tag);
    n_checks++;
    if ({grant, done, mem_cs_n, mem_adv_n, mem_oe_n, mem_we_n, mem_dq_oe, mem_addr, mem_dq_o, rdata}
        !== {4'b0, 4'b0, 5'b11110, {AW{1'b0}}, {DW{1'b0}}, {DW{1'b0}}}) begin
      n_fail++;
      $display("FAIL %s: grant=%b done=%b strobes=%b%b%b%b%b addr=%h dq_o=%h rdata=%h required all idle/zero",
               tag, grant, done, mem_cs_n, mem_adv_n, mem_oe_n, mem_we_n, mem_dq_oe, mem_addr, mem_dq_o, rdata);
    end
  endtask

  task automatic test_reset();
    req = 4'b1111;
    @(negedge clk);
    check_reset_state("reset_hold");
    @(negedge clk);
    check_reset_state("reset_hold2");
    req = '0;
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_state("reset_release_idle");
    $display("reset released");
  endtask

  task automatic test_single_read();
    addr[3*AW +: AW] = 24'h000123;
    we = 4'b0000;
    mem_dq_i = 16'hBEEF;
    req = 4'b1000;
    observe(model_pick(req), 0);
    req = '0;
  endtask

  task automatic test_single_write();
    addr[2*AW +: AW]  = 24'h0000FF;
    wdata[2*DW +: DW] = 16'h1234;
    we = 4'b0100;
    req = 4'b0100;
    observe(model_pick(req), 0);
    req = '0;
  endtask

  task automatic test_back_to_back();
    randomize_inputs();
    mem_dq_i = DW'($urandom);
    req = 4'b1111;
    for (int i = 0; i < 5; i++) observe(model_pick(req), 0);
    req = '0;
  endtask

  task automatic test_req_drop();
    randomize_inputs();
    we[1] = 1'b0;
    mem_dq_i = DW'($urandom);
    req = 4'b0010;
    observe(model_pick(req), 2);
    req = '0;
  endtask

  task automatic test_reset_mid();
    randomize_inputs();
    mem_dq_i = DW'($urandom);
    req = 4'b0001;
    repeat (5) @(negedge clk);  // SETUP + ACCESS 1..4
    #1 rst_n = 1'b0;
    rr_next = 0;
    exp_rdata = '0;
    #1 check_reset_state("reset_mid_async");
    repeat (2) begin
      @(negedge clk);
      check_reset_state("reset_mid_hold");
    end
    rst_n = 1'b1;
    observe(model_pick(req), 0);
    req = '0;
  endtask

  task automatic test_contention();
    int w;
    for (int round = 0; round < 8; round++) begin
      randomize_inputs();
      req = 4'($urandom_range(1, 15));
      for (int n = 0; n < 4 && req != 4'b0; n++) begin
        mem_dq_i = DW'($urandom);
        w = model_pick(req);
        observe(w, int'($urandom_range(0, 1)));
        req[w] = 1'b0;
      end
    end
    // Every requester was served exactly once, so nothing may be pending.
    @(negedge clk);
    n_checks++;
    if (grant !== 4'b0) begin
      n_fail++;
      $display("FAIL contention_drain: grant=%b required 0000", grant);
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_single_write();
    test_back_to_back();
    test_req_drop();
    test_reset_mid();
    test_contention();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 24, SHALL set the external RAM word-address width.
REQ-002 Parameter DATA_WIDTH, default 16, SHALL set the RAM data width.
REQ-003 Parameter ACCESS_CYCLES, default 7, range 1-15, SHALL set the cycles the strobe is held low per access.
REQ-004 Port clk, input, 1: the single clock; all state SHALL change on its rising edge.
REQ-005 Port rst_n, input, 1: asynchronous reset, active low.
REQ-006 Ports req, we, input, 4 each: per-requester request and write-enable; index 0 VGA, 1 audio, 2 IO, 3 core.
REQ-007 Ports addr, input, 4xADDR_WIDTH packed, and wdata, input, 4xDATA_WIDTH packed: per-requester address and write data.
REQ-008 Port grant, output, 4: one-hot owner of the current access.
REQ-009 Port done, output, 4: one-cycle completion pulse to the owner.
REQ-010 Port rdata, output, DATA_WIDTH: read data from the last completed read.
REQ-011 RAM ports SHALL be: mem_addr out ADDR_WIDTH; mem_dq_o out DATA_WIDTH; mem_dq_oe out 1; mem_dq_i in DATA_WIDTH; mem_cs_n, mem_adv_n, mem_oe_n, mem_we_n out 1.

Function
REQ-012 The FSM SHALL have the states IDLE, SETUP, ACCESS and RECOVER.
REQ-013 IDLE with any req high: pick the winner, latch its addr/wdata/we, set grant, and go to SETUP; otherwise stay in IDLE.
REQ-014 SETUP SHALL last 1 cycle: mem_cs_n=0, mem_adv_n=0, mem_addr valid.
REQ-015 ACCESS SHALL last exactly ACCESS_CYCLES cycles, timed by a 4-bit down-counter: mem_cs_n=0, mem_adv_n=1; reads drive mem_oe_n=0; writes drive mem_we_n=0.
REQ-016 Writes SHALL assert mem_dq_oe and drive mem_dq_o from SETUP through the last ACCESS cycle; mem_dq_oe SHALL be 0 otherwise.
REQ-017 A read SHALL capture mem_dq_i into rdata on the last ACCESS cycle edge; rdata SHALL hold until the next read completes.
REQ-018 RECOVER SHALL last 1 cycle with mem_cs_n=1 and done[owner]=1; the next state SHALL be IDLE and grant SHALL clear on exit.
REQ-019 Latency: req sampled in IDLE at cycle 0 SHALL give done at cycle ACCESS_CYCLES+2; back-to-back throughput SHALL be one access per ACCESS_CYCLES+3 cycles.
REQ-020 Once granted, an access SHALL complete even if req drops; done SHALL still pulse.
REQ-021 A requester SHALL hold req, addr, we and wdata until done; the arbiter SHALL ignore changes on these after the IDLE latch.
REQ-022 A req held after done SHALL be re-arbitrated as a new request.
REQ-023 Simultaneous requests SHALL resolve in the same IDLE cycle per REQ-028; losers SHALL wait with no loss.
REQ-024 mem_addr and mem_dq_o SHALL hold their last value when idle.

Reset
REQ-025 rst_n low SHALL immediately force: IDLE; grant=0; done=0; mem_cs_n, mem_adv_n, mem_oe_n, mem_we_n=1; mem_dq_oe=0; counter=0.
REQ-026 rst_n low SHALL also clear rdata, mem_addr, mem_dq_o and the round-robin pointer to 0.
REQ-027 Reset mid-access SHALL abort without a done pulse; the first request after release SHALL arbitrate normally.

Configuration
REQ-028 With MEM_ARB_ROUND_ROBIN_EN defined, the arbiter SHALL use round-robin: search starts at last_grant+1 mod 4, and the pointer updates on each grant.
REQ-029 Without MEM_ARB_ROUND_ROBIN_EN, the arbiter SHALL use fixed priority 0>1>2>3, and no pointer register SHALL exist.

Structure
REQ-030 Package mem_arb_pkg SHALL hold: the state enum, NUM_REQ=4, and the index constants REQ_VGA=0, REQ_AUDIO=1, REQ_IO=2, REQ_CORE=3.
REQ-031 Winner selection SHALL live in one combinational sub-module, arb_picker (inputs req and pointer; output one-hot winner).

Verification (ACCESS_CYCLES=7)
REQ-032 Single read by core at addr 0x000123, mem_dq_i=0xBEEF -> mem_oe_n low for 7 cycles, done[3] at cycle 9, rdata=0xBEEF.
REQ-033 Single write by IO of 0x1234 to 0x0000FF -> mem_we_n low for 7 cycles, mem_dq_oe high for 8 cycles, mem_dq_o=0x1234, done[2] at cycle 9.
REQ-034 req=4'b1111 held continuously, round-robin built -> grant order 0,1,2,3,0 and done spacing 10 cycles; without the macro -> grant stays on requester 0.
REQ-035 req[1] dropped in the 3rd ACCESS cycle -> access completes and done[1] still pulses.
REQ-036 rst_n low in the 4th ACCESS cycle -> all strobes high asynchronously, no done; req[0] after release -> done[0] 9 cycles later.
